// File: rtl/memory_sram_bridge_pkg.sv
// rtl/memory_sram_bridge_pkg.sv - shared types and helpers for the SRAM bridge
// Purpose: FSM state encoding, memory ORDER encodings, read-pipe tag type and
//          the alignment-fault helper used when MEMORY_SRAM_BRIDGE_ALIGN_CHECK_EN
//          is defined.
package memory_sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_LO,
        RD_HI,
        RD_WAIT,
        RESP
    } state_e;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_NONE = 2'b11;

    // One entry per SRAM read strobe: which half of the 64-bit response it fills.
    typedef struct packed {
        logic valid;
        logic hi;
    } rd_tag_t;

    function automatic logic align_fault(input logic [1:0] order, input logic [1:0] addr_lo);
        logic f;
        case (order)
            ORDER_HALF: f = addr_lo[0];
            ORDER_WORD: f = |addr_lo;
            ORDER_BYTE: f = 1'b0;
            ORDER_NONE: f = 1'b0;
            default:    f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/memory_sram_bridge_rd_pipe.sv
// rtl/memory_sram_bridge_rd_pipe.sv - read-tag delay line matching SRAM read latency
// Purpose: tags every SRAM read strobe and raises a capture strobe for the lo or
//          hi response word exactly P_RD_LAT cycles after the strobe.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clr_i             synchronous clear (drops all outstanding tags)
//   push_i, push_hi_i read strobe this cycle, and whether it is the hi word
//   cap_lo_o/cap_hi_o capture iSRAM_RDATA into the lo/hi response word now
module memory_sram_bridge_rd_pipe
    import memory_sram_bridge_pkg::*;
#(
    parameter int P_RD_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic push_i,
    input  logic push_hi_i,
    output logic cap_lo_o,
    output logic cap_hi_o
);

    rd_tag_t pipe_q [P_RD_LAT];
    rd_tag_t tag_d;

    assign tag_d = '{valid: push_i, hi: push_hi_i};

    // Stage k holds the tag of a strobe issued k+1 cycles ago, so the last
    // stage lines up with the cycle the SRAM presents that word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < P_RD_LAT; i++) pipe_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < P_RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_d;
            for (int i = 1; i < P_RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign cap_lo_o = pipe_q[P_RD_LAT-1].valid && !pipe_q[P_RD_LAT-1].hi;
    assign cap_hi_o = pipe_q[P_RD_LAT-1].valid &&  pipe_q[P_RD_LAT-1].hi;

endmodule

// File: rtl/memory_sram_bridge.sv
// rtl/memory_sram_bridge.sv - processor memory port to synchronous 32-bit SRAM bridge
// Purpose: accepts one request at a time; writes one masked word, reads two
//          consecutive words and returns them as one 64-bit beat with VALID/BUSY.
// Config macro: MEMORY_SRAM_BRIDGE_ALIGN_CHECK_EN enables the alignment-fault
//          path and oERROR; without it ORDER is ignored and oERROR is 0.
// Ports:
//   iCLOCK, iRESET (async), iRESET_SYNC (sync clear)
//   iMEMORY_REQ/ORDER/MASK/RW/ADDR/DATA, oMEMORY_LOCK   request side
//   oMEMORY_VALID, iMEMORY_BUSY, oMEMORY_DATA           response side
//   oSRAM_CE/WE/BE/ADDR/WDATA, iSRAM_RDATA              SRAM side
//   oERROR                                              alignment-fault pulse
module memory_sram_bridge
    import memory_sram_bridge_pkg::*;
#(
    parameter int P_ADDR_W = 16,
    parameter int P_RD_LAT = 1
) (
    input  logic                iCLOCK,
    input  logic                iRESET,
    input  logic                iRESET_SYNC,
    input  logic                iMEMORY_REQ,
    output logic                oMEMORY_LOCK,
    input  logic [1:0]          iMEMORY_ORDER,
    input  logic [3:0]          iMEMORY_MASK,
    input  logic                iMEMORY_RW,
    input  logic [31:0]         iMEMORY_ADDR,
    input  logic [31:0]         iMEMORY_DATA,
    output logic                oMEMORY_VALID,
    input  logic                iMEMORY_BUSY,
    output logic [63:0]         oMEMORY_DATA,
    output logic                oSRAM_CE,
    output logic                oSRAM_WE,
    output logic [3:0]          oSRAM_BE,
    output logic [P_ADDR_W-1:0] oSRAM_ADDR,
    output logic [31:0]         oSRAM_WDATA,
    input  logic [31:0]         iSRAM_RDATA,
    output logic                oERROR
);

    state_e                state_q, state_d;
    logic                  lock_q;
    logic                  err_q, err_d;
    logic [P_ADDR_W-1:0]   waddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            mask_q;
    logic [63:0]           data_q;
    logic                  accept;
    logic                  fault;
    logic                  rd_push_lo, rd_push_hi;
    logic                  cap_lo, cap_hi;
    logic                  unused_inputs;

    assign accept = iMEMORY_REQ && (state_q == IDLE);

`ifdef MEMORY_SRAM_BRIDGE_ALIGN_CHECK_EN
    assign fault = align_fault(iMEMORY_ORDER, iMEMORY_ADDR[1:0]);
`else
    assign fault = 1'b0;
`endif

    // Byte-lane and out-of-range address bits never reach the SRAM.
    assign unused_inputs = ^{iMEMORY_ORDER, iMEMORY_ADDR[31:P_ADDR_W+2], iMEMORY_ADDR[1:0]};

    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        rd_push_lo  = 1'b0;
        rd_push_hi  = 1'b0;
        oSRAM_CE    = 1'b0;
        oSRAM_WE    = 1'b0;
        oSRAM_BE    = 4'h0;
        oSRAM_ADDR  = '0;
        oSRAM_WDATA = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        // Faulting write is dropped; faulting read answers with zeros.
                        err_d   = 1'b1;
                        state_d = iMEMORY_RW ? IDLE : RESP;
                    end else begin
                        state_d = iMEMORY_RW ? WR : RD_LO;
                    end
                end
            end
            WR: begin
                oSRAM_CE    = 1'b1;
                oSRAM_WE    = 1'b1;
                oSRAM_BE    = mask_q;
                oSRAM_ADDR  = waddr_q;
                oSRAM_WDATA = wdata_q;
                state_d     = IDLE;
            end
            RD_LO: begin
                oSRAM_CE   = 1'b1;
                oSRAM_BE   = 4'hF;
                oSRAM_ADDR = {waddr_q[P_ADDR_W-1:1], 1'b0};
                rd_push_lo = 1'b1;
                state_d    = RD_HI;
            end
            RD_HI: begin
                // The lo word is even, so setting bit 0 is the +1 word and cannot carry.
                oSRAM_CE   = 1'b1;
                oSRAM_BE   = 4'hF;
                oSRAM_ADDR = {waddr_q[P_ADDR_W-1:1], 1'b1};
                rd_push_hi = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (cap_hi) state_d = RESP;
            end
            RESP: begin
                if (!iMEMORY_BUSY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            data_q  <= 64'h0;
        end else if (iRESET_SYNC) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            data_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            // LOCK tracks the state being entered so it is already 0 in the first IDLE cycle.
            lock_q  <= (state_d != IDLE);
            err_q   <= err_d;
            if (accept) begin
                waddr_q <= iMEMORY_ADDR[P_ADDR_W+1:2];
                wdata_q <= iMEMORY_DATA;
                mask_q  <= iMEMORY_MASK;
            end
            if (accept && fault) data_q <= 64'h0;
            if (cap_lo) data_q[31:0]  <= iSRAM_RDATA;
            if (cap_hi) data_q[63:32] <= iSRAM_RDATA;
        end
    end

    memory_sram_bridge_rd_pipe #(
        .P_RD_LAT (P_RD_LAT)
    ) u_rd_pipe (
        .clk_i     (iCLOCK),
        .rst_i     (iRESET),
        .clr_i     (iRESET_SYNC),
        .push_i    (rd_push_lo | rd_push_hi),
        .push_hi_i (rd_push_hi),
        .cap_lo_o  (cap_lo),
        .cap_hi_o  (cap_hi)
    );

    assign oMEMORY_LOCK  = lock_q;
    assign oMEMORY_VALID = (state_q == RESP);
    assign oMEMORY_DATA  = data_q;
    assign oERROR        = err_q;

endmodule

// File: tb/tb_memory_sram_bridge.sv
// tb/tb_memory_sram_bridge.sv - self-checking bench for memory_sram_bridge
module tb_memory_sram_bridge;

    localparam int P_AW = 16;
    localparam int P_L  = 3;

    logic            clk = 1'b0;
    logic            rst, rst_sync, req, rw, busy;
    logic [1:0]      order;
    logic [3:0]      mask;
    logic [31:0]     addr, wdata, rdata;
    logic            lock, valid, ce, we, err;
    logic [63:0]     mdata;
    logic [3:0]      be;
    logic [P_AW-1:0] saddr;
    logic [31:0]     swdata;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [31:0] sram_mem [0:65535];
    logic [31:0] ref_mem  [0:65535];
    logic [31:0] rd_sh    [P_L];

    always #5 clk = ~clk;

    memory_sram_bridge #(
        .P_ADDR_W (P_AW),
        .P_RD_LAT (P_L)
    ) u_dut (
        .iCLOCK        (clk),
        .iRESET        (rst),
        .iRESET_SYNC   (rst_sync),
        .iMEMORY_REQ   (req),
        .oMEMORY_LOCK  (lock),
        .iMEMORY_ORDER (order),
        .iMEMORY_MASK  (mask),
        .iMEMORY_RW    (rw),
        .iMEMORY_ADDR  (addr),
        .iMEMORY_DATA  (wdata),
        .oMEMORY_VALID (valid),
        .iMEMORY_BUSY  (busy),
        .oMEMORY_DATA  (mdata),
        .oSRAM_CE      (ce),
        .oSRAM_WE      (we),
        .oSRAM_BE      (be),
        .oSRAM_ADDR    (saddr),
        .oSRAM_WDATA   (swdata),
        .iSRAM_RDATA   (rdata),
        .oERROR        (err)
    );

    // SRAM model: byte-masked writes, reads appear P_L cycles after CE; junk otherwise.
    always @(posedge clk) begin
        if (ce && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) sram_mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
        end
        rd_sh[0] <= (ce && !we) ? sram_mem[saddr] : 32'hBAD0BAD0;
        for (int i = 1; i < P_L; i++) rd_sh[i] <= rd_sh[i-1];
    end
    assign rdata = rd_sh[P_L-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        sram_mem[i] = v;
        ref_mem[i]  = v;
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [15:0] w;
        w = a[17:2];
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_read(input logic [31:0] a);
        logic [15:0] lo, hi;
        lo = {a[17:3], 1'b0};
        hi = {a[17:3], 1'b1};
        exp_q.push_back({ref_mem[hi], ref_mem[lo]});
    endtask

    // Called at a negedge; returns at the negedge in the middle of cycle 1 (accept = cycle 0).
    task automatic issue(input logic r, input logic [1:0] o, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d, output int waits);
        req = 1'b1; rw = r; order = o; mask = m; addr = a; wdata = d;
        waits = 0;
        while (lock !== 1'b0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_timeout", 64'(waits < 50), 64'd1);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        int w, n;
        push_read(a);
        issue(1'b0, 2'b10, 4'hF, a, 32'h0, w);
        wait_valid(1, n);
        chk({tag, "_latency"}, 64'(n), 64'(3 + P_L));
        chk({tag, "_data"}, mdata, exp_q.pop_front());
        chk({tag, "_err"}, 64'(err), 64'd0);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
        chk({tag, "_lock_drop"}, 64'(lock), 64'd0);
    endtask

    initial begin
        int w, n;
        logic [63:0] held;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        for (int i = 0; i < P_L; i++) rd_sh[i] = 32'h0;
        set_word(0, 32'h0A0B0C0D);
        set_word(1, 32'h01020304);
        set_word(2, 32'h11111111);
        set_word(3, 32'h22222222);
        rst = 1'b1; rst_sync = 1'b0; req = 1'b0; rw = 1'b0; busy = 1'b0;
        order = 2'b10; mask = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("reset_sram", {ce, we, be, 16'(saddr), swdata}, 64'h0);
        chk("reset_resp", {valid, lock, err}, 64'h0);
        chk("reset_data", mdata, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Masked write
        ref_write(32'h10, 4'b0011, 32'hDEADBEEF);
        issue(1'b1, 2'b10, 4'b0011, 32'h10, 32'hDEADBEEF, w);
        chk("wr_ce_we", {ce, we}, 64'h3);
        chk("wr_addr", 64'(saddr), 64'd4);
        chk("wr_be", 64'(be), 64'h3);
        chk("wr_wdata", 64'(swdata), 64'hDEADBEEF);
        chk("wr_lock", 64'(lock), 64'd1);
        @(negedge clk);
        chk("wr_ce_done", 64'(ce), 64'd0);
        chk("wr_lock_done", 64'(lock), 64'd0);

        // Read of words 2 and 3, checking the SRAM strobe sequence
        push_read(32'h0C);
        issue(1'b0, 2'b10, 4'hF, 32'h0C, 32'h0, w);
        chk("rd_lo_strobe", {ce, we, be, 16'(saddr)}, {56'h0, 1'b1, 1'b0, 4'hF} << 16 | 64'd2);
        @(negedge clk);
        chk("rd_hi_strobe", {ce, we, be, 16'(saddr)}, {56'h0, 1'b1, 1'b0, 4'hF} << 16 | 64'd3);
        wait_valid(2, n);
        chk("rd_latency", 64'(n), 64'(3 + P_L));
        chk("rd_data", mdata, exp_q.pop_front());
        chk("rd_data_const", mdata, 64'h22222222_11111111);
        @(negedge clk);
        chk("rd_valid_drop", 64'(valid), 64'd0);

        do_read("rd_after_wr", 32'h10);

        // Backpressure during RESP
        busy = 1'b1;
        push_read(32'h08);
        issue(1'b0, 2'b10, 4'hF, 32'h08, 32'h0, w);
        wait_valid(1, n);
        held = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(valid), 64'd1);
            chk("bp_data", mdata, held);
            chk("bp_lock", 64'(lock), 64'd1);
            @(negedge clk);
        end
        busy = 1'b0;
        chk("bp_release_data", mdata, held);
        @(negedge clk);
        chk("bp_idle", {valid, lock}, 64'h0);

        // Back-to-back write then read of the same word
        ref_write(32'h0C, 4'b1100, 32'hAABBCCDD);
        issue(1'b1, 2'b10, 4'b1100, 32'h0C, 32'hAABBCCDD, w);
        push_read(32'h0C);
        issue(1'b0, 2'b10, 4'hF, 32'h0C, 32'h0, w);
        chk("b2b_accept_cycle2", 64'(w), 64'd1);
        wait_valid(1, n);
        chk("b2b_latency", 64'(n), 64'(3 + P_L));
        chk("b2b_data", mdata, exp_q.pop_front());
        chk("b2b_data_const", mdata, 64'hAABB2222_11111111);
        @(negedge clk);

        do_read("rd_alias", 32'h0004_000C);

        // Asynchronous reset while in RD_WAIT
        issue(1'b0, 2'b10, 4'hF, 32'h08, 32'h0, w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_outputs", {ce, we, be, valid, lock, err}, 64'h0);
        chk("arst_data", mdata, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (P_L + 2) @(negedge clk);
        chk("arst_late_valid", 64'(valid), 64'd0);
        chk("arst_late_data", mdata, 64'h0);
        do_read("rd_after_arst", 32'h0C);

        // Synchronous clear during RD_LO
        issue(1'b0, 2'b10, 4'hF, 32'h00, 32'h0, w);
        rst_sync = 1'b1;
        @(negedge clk);
        chk("srst_outputs", {ce, valid, lock, err}, 64'h0);
        chk("srst_data", mdata, 64'h0);
        rst_sync = 1'b0;
        repeat (P_L + 3) @(negedge clk);
        chk("srst_late", {valid, 63'(mdata)}, 64'h0);
        do_read("rd_after_srst", 32'h00);

`ifdef MEMORY_SRAM_BRIDGE_ALIGN_CHECK_EN
        issue(1'b1, 2'b10, 4'hF, 32'h2, 32'h12345678, w);
        chk("al_wr_no_ce", 64'(ce), 64'd0);
        chk("al_wr_err", 64'(err), 64'd1);
        @(negedge clk);
        chk("al_wr_err_pulse", {ce, err}, 64'h0);
        issue(1'b0, 2'b10, 4'hF, 32'h1, 32'h0, w);
        chk("al_rd_valid", 64'(valid), 64'd1);
        chk("al_rd_data", mdata, 64'h0);
        chk("al_rd_err", 64'(err), 64'd1);
        @(negedge clk);
        chk("al_rd_done", {valid, err}, 64'h0);
        do_read("al_mem_untouched", 32'h00);
`else
        ref_write(32'h2, 4'hF, 32'h12345678);
        issue(1'b1, 2'b10, 4'hF, 32'h2, 32'h12345678, w);
        chk("noal_wr_ce", {ce, we}, 64'h3);
        chk("noal_wr_addr", 64'(saddr), 64'd0);
        chk("noal_wr_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("noal_wr_err2", 64'(err), 64'd0);
        do_read("noal_rd", 32'h1);
        chk("noal_rd_err", 64'(err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
